// File: rtl/rgb2hsv_stream.sv
// rgb2hsv_stream: fully pipelined RGB-to-HSV converter, CW+4 cycle latency, global ce stall.
// Define RGB2HSV_ROUND_EN to round both quotients half-up in the final stage.
module rgb2hsv_stream #(
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          in_valid,
    input  logic [CW-1:0] r,
    input  logic [CW-1:0] g,
    input  logic [CW-1:0] b,
    output logic          out_valid,
    output logic [CW-1:0] h,
    output logic [CW-1:0] s,
    output logic [CW-1:0] v
);
    localparam int DW = 2 * CW;
    localparam int VW = CW + 3;
    localparam int MAXV_I = (1 << CW) - 1;
    localparam logic [CW-1:0] MAXV  = CW'(MAXV_I);
    localparam logic [CW-1:0] OFF_G = CW'(MAXV_I / 3);
    localparam logic [CW-1:0] OFF_B = CW'((2 * MAXV_I) / 3);
`ifdef RGB2HSV_ROUND_EN
    localparam int REM_LAST = CW;
`else
    localparam int REM_LAST = CW - 1;
`endif

    typedef enum logic [1:0] {SEC_R = 2'd0, SEC_G = 2'd1, SEC_B = 2'd2} sector_t;

    // Stage 1: input capture
    logic          s1_valid;
    logic [CW-1:0] s1_r, s1_g, s1_b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
        end else if (ce) begin
            s1_valid <= in_valid;
            s1_r     <= r;
            s1_g     <= g;
            s1_b     <= b;
        end
    end

    // Stage 2: max/min, sector (r wins ties, then g), sign of the hue numerator
    sector_t       sec_c;
    logic [CW-1:0] max_c, min_c;
    logic          neg_c;

    always_comb begin
        sec_c = SEC_R;
        max_c = s1_r;
        neg_c = 1'b0;
        if (s1_r >= s1_g && s1_r >= s1_b) begin
            sec_c = SEC_R;
            max_c = s1_r;
            neg_c = s1_g < s1_b;
        end else if (s1_g >= s1_b) begin
            sec_c = SEC_G;
            max_c = s1_g;
            neg_c = s1_b < s1_r;
        end else begin
            sec_c = SEC_B;
            max_c = s1_b;
            neg_c = s1_r < s1_g;
        end
        min_c = s1_r;
        if (s1_g < min_c) min_c = s1_g;
        if (s1_b < min_c) min_c = s1_b;
    end

    logic          s2_valid;
    logic [CW-1:0] s2_r, s2_g, s2_b, s2_max, s2_min;
    sector_t       s2_sec;
    logic          s2_neg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_r     <= '0;
            s2_g     <= '0;
            s2_b     <= '0;
            s2_max   <= '0;
            s2_min   <= '0;
            s2_sec   <= SEC_R;
            s2_neg   <= 1'b0;
        end else if (ce) begin
            s2_valid <= s1_valid;
            s2_r     <= s1_r;
            s2_g     <= s1_g;
            s2_b     <= s1_b;
            s2_max   <= max_c;
            s2_min   <= min_c;
            s2_sec   <= sec_c;
            s2_neg   <= neg_c;
        end
    end

    // Stage 3: delta, |num|, dividends, divisors, hue offset
    logic [CW-1:0] delta_c, anum_c, off_c;
    logic [DW-1:0] dvd_s_c, dvd_h_c;
    logic [VW-1:0] dvs_s_c, dvs_h_c;

    always_comb begin
        delta_c = s2_max - s2_min;
        anum_c  = '0;
        off_c   = '0;
        case (s2_sec)
            SEC_G: begin
                off_c  = OFF_G;
                anum_c = s2_neg ? (s2_r - s2_b) : (s2_b - s2_r);
            end
            SEC_B: begin
                off_c  = OFF_B;
                anum_c = s2_neg ? (s2_g - s2_r) : (s2_r - s2_g);
            end
            default: begin
                off_c  = '0;
                anum_c = s2_neg ? (s2_b - s2_g) : (s2_g - s2_b);
            end
        endcase
        dvd_s_c = DW'(MAXV) * DW'(delta_c);
        dvd_h_c = DW'(MAXV) * DW'(anum_c);
        // A zero divisor only ever meets a zero dividend, so dividing by 1 gives the required 0.
        dvs_s_c = (s2_max == '0) ? VW'(1) : VW'(s2_max);
        dvs_h_c = (delta_c == '0) ? VW'(1) : VW'(delta_c) * VW'(6);
    end

    // Index 0 is the stage-3 register; index k holds the state after k quotient bits.
    logic          vld   [0:CW];
    logic [CW-1:0] val   [0:CW];
    logic [CW-1:0] off   [0:CW];
    logic          neg   [0:CW];
    logic [DW-1:0] rem_s [0:REM_LAST];
    logic [DW-1:0] rem_h [0:REM_LAST];
    logic [VW-1:0] dvs_s [0:REM_LAST];
    logic [VW-1:0] dvs_h [0:REM_LAST];
    logic [CW-1:0] q_s   [1:CW];
    logic [CW-1:0] q_h   [1:CW];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld[0]   <= 1'b0;
            val[0]   <= '0;
            off[0]   <= '0;
            neg[0]   <= 1'b0;
            rem_s[0] <= '0;
            rem_h[0] <= '0;
            dvs_s[0] <= '0;
            dvs_h[0] <= '0;
        end else if (ce) begin
            vld[0]   <= s2_valid;
            val[0]   <= s2_max;
            off[0]   <= off_c;
            neg[0]   <= s2_neg;
            rem_s[0] <= dvd_s_c;
            rem_h[0] <= dvd_h_c;
            dvs_s[0] <= dvs_s_c;
            dvs_h[0] <= dvs_h_c;
        end
    end

    // Restoring divide, MSB first: stage k decides quotient bit CW-k for both dividers.
    for (genvar k = 1; k <= CW; k++) begin : g_div
        localparam int SH = CW - k;
        logic [DW+2:0] sh_s, sh_h;
        logic          ge_s, ge_h;
        logic [CW-1:0] qp_s, qp_h, qn_s, qn_h;

        assign sh_s = (DW + 3)'(dvs_s[k-1]) << SH;
        assign sh_h = (DW + 3)'(dvs_h[k-1]) << SH;
        assign ge_s = {3'b000, rem_s[k-1]} >= sh_s;
        assign ge_h = {3'b000, rem_h[k-1]} >= sh_h;

        if (k == 1) begin : g_q_first
            assign qp_s = '0;
            assign qp_h = '0;
        end else begin : g_q_next
            assign qp_s = q_s[k-1];
            assign qp_h = q_h[k-1];
        end
        assign qn_s = qp_s | (CW'(ge_s) << SH);
        assign qn_h = qp_h | (CW'(ge_h) << SH);

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                vld[k] <= 1'b0;
                val[k] <= '0;
                off[k] <= '0;
                neg[k] <= 1'b0;
                q_s[k] <= '0;
                q_h[k] <= '0;
            end else if (ce) begin
                vld[k] <= vld[k-1];
                val[k] <= val[k-1];
                off[k] <= off[k-1];
                neg[k] <= neg[k-1];
                q_s[k] <= qn_s;
                q_h[k] <= qn_h;
            end
        end

        if (k <= REM_LAST) begin : g_rem
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    rem_s[k] <= '0;
                    rem_h[k] <= '0;
                    dvs_s[k] <= '0;
                    dvs_h[k] <= '0;
                end else if (ce) begin
                    rem_s[k] <= ge_s ? (rem_s[k-1] - sh_s[DW-1:0]) : rem_s[k-1];
                    rem_h[k] <= ge_h ? (rem_h[k-1] - sh_h[DW-1:0]) : rem_h[k-1];
                    dvs_s[k] <= dvs_s[k-1];
                    dvs_h[k] <= dvs_h[k-1];
                end
            end
        end
    end

    // Final stage: optional rounding, hue offset and wrap-around
    logic [CW-1:0] qs_f, qh_f, h_c;

    always_comb begin
        qs_f = q_s[CW];
        qh_f = q_h[CW];
`ifdef RGB2HSV_ROUND_EN
        if ({rem_s[CW], 1'b0} >= (DW + 1)'(dvs_s[CW])) qs_f = qs_f + CW'(1);
        if ({rem_h[CW], 1'b0} >= (DW + 1)'(dvs_h[CW])) qh_f = qh_f + CW'(1);
`endif
        h_c = '0;
        if (!neg[CW])
            h_c = off[CW] + qh_f;
        else if (qh_f > off[CW])
            h_c = MAXV - qh_f + off[CW];
        else
            h_c = off[CW] - qh_f;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            h         <= '0;
            s         <= '0;
            v         <= '0;
        end else if (ce) begin
            out_valid <= vld[CW];
            if (vld[CW]) begin
                h <= h_c;
                s <= qs_f;
                v <= val[CW];
            end
        end
    end

endmodule

// File: tb/tb_rgb2hsv_stream.sv
// Bench for rgb2hsv_stream at CW=8: latency, directed colours, streaming, stall and reset.
// Expected results come from a plain integer reference model or fixed tables.
module tb_rgb2hsv_stream;
    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;
    localparam int LAT  = CW + 4;
`ifdef RGB2HSV_ROUND_EN
    localparam int S_HALF = 128;
    localparam int H_TIE  = 43;
`else
    localparam int S_HALF = 127;
    localparam int H_TIE  = 42;
`endif

    logic          clock, reset, ce, in_valid, out_valid;
    logic [CW-1:0] r, g, b, h, s, v;
    logic [3*CW-1:0] exp_q[$];
    logic [3*CW-1:0] last_exp = '0;
    int checks = 0;
    int errors = 0;

    rgb2hsv_stream #(.CW(CW)) dut (
        .clock(clock), .reset(reset), .ce(ce), .in_valid(in_valid),
        .r(r), .g(g), .b(b),
        .out_valid(out_valid), .h(h), .s(s), .v(v)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [3*CW-1:0] ref_hsv(input int rr, input int gg, input int bb);
        int mx, mn, d, num, an, offs, q, qs, hh;
        mx = rr; if (gg > mx) mx = gg; if (bb > mx) mx = bb;
        mn = rr; if (gg < mn) mn = gg; if (bb < mn) mn = bb;
        d = mx - mn;
        if (rr >= gg && rr >= bb) begin num = gg - bb; offs = 0; end
        else if (gg >= bb) begin num = bb - rr; offs = MAXV / 3; end
        else begin num = rr - gg; offs = (2 * MAXV) / 3; end
        an = (num < 0) ? -num : num;
        hh = 0;
        qs = 0;
        if (d != 0) begin
            q  = (MAXV * an) / (6 * d);
            qs = (MAXV * d) / mx;
`ifdef RGB2HSV_ROUND_EN
            if (2 * ((MAXV * an) % (6 * d)) >= 6 * d) q++;
            if (2 * ((MAXV * d) % mx) >= mx) qs++;
`endif
            if (num >= 0) hh = offs + q;
            else if (q > offs) hh = MAXV - q + offs;
            else hh = offs - q;
        end
        return {hh[CW-1:0], qs[CW-1:0], mx[CW-1:0]};
    endfunction

    // Scoreboard: one pop per out_valid beat that the pipeline actually advances on
    always @(negedge clock) begin
        if (!reset && ce && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got unexpected beat h=%0d s=%0d v=%0d", h, s, v);
            end else begin
                last_exp = exp_q.pop_front();
                if ({h, s, v} !== last_exp) begin
                    errors++;
                    $display("FAIL scoreboard: got h=%0d s=%0d v=%0d, expected h=%0d s=%0d v=%0d",
                             h, s, v, last_exp[3*CW-1:2*CW], last_exp[2*CW-1:CW], last_exp[CW-1:0]);
                end
            end
        end
    end

    task automatic drive_pixel(input int rr, input int gg, input int bb, input logic [3*CW-1:0] e);
        in_valid = 1'b1;
        r = CW'(rr);
        g = CW'(gg);
        b = CW'(bb);
        exp_q.push_back(e);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4 * LAT && exp_q.size() != 0; i++) begin
            @(posedge clock); #1;
        end
        repeat (2) begin @(posedge clock); #1; end
    endtask

    task automatic test_reset();
        @(posedge clock); #1;
        checks++;
        if ({out_valid, h, s, v} !== {1'b0, {3*CW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: got ov=%0b h=%0d s=%0d v=%0d, expected all 0", out_valid, h, s, v);
        end
        #2 reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ov=%0b, expected 0", out_valid);
        end
    endtask

    task automatic test_latency();
        int seen;
        in_valid = 1'b1; r = CW'(255); g = '0; b = '0;
        exp_q.push_back({CW'(0), CW'(255), CW'(255)});
        seen = 0;
        for (int n = 1; n <= 3 * LAT && seen == 0; n++) begin
            @(posedge clock); #1;
            in_valid = 1'b0;
            if (out_valid) seen = n;
        end
        checks++;
        if (seen !== LAT) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected %0d", seen, LAT);
        end
        wait_drain();
    endtask

    task automatic test_directed();
        int tv [8][6] = '{
            '{0, 255, 0, 85, 255, 255},
            '{0, 0, 255, 170, 255, 255},
            '{0, 0, 0, 0, 0, 0},
            '{128, 128, 128, 0, 0, 128},
            '{200, 200, 100, H_TIE, S_HALF, 200},
            '{255, 0, 128, 234, 255, 255},
            '{200, 150, 100, 21, S_HALF, 200},
            '{255, 255, 255, 0, 0, 255}
        };
        for (int i = 0; i < 8; i++)
            drive_pixel(tv[i][0], tv[i][1], tv[i][2],
                        {CW'(tv[i][3]), CW'(tv[i][4]), CW'(tv[i][5])});
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL directed_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int rr, gg, bb, first, last, total;
        first = 0; last = 0; total = 0;
        for (int n = 1; n <= 20 + LAT + 4; n++) begin
            if (n <= 20) begin
                rr = $urandom_range(0, MAXV);
                gg = $urandom_range(0, MAXV);
                bb = $urandom_range(0, MAXV);
                in_valid = 1'b1;
                r = CW'(rr); g = CW'(gg); b = CW'(bb);
                exp_q.push_back(ref_hsv(rr, gg, bb));
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clock); #1;
            if (out_valid) begin
                total++;
                if (first == 0) first = n;
                last = n;
            end
        end
        checks++;
        if (total !== 20 || last - first !== 19 || first !== LAT) begin
            errors++;
            $display("FAIL back_to_back: got %0d beats from %0d to %0d, expected 20 from %0d to %0d",
                     total, first, last, LAT, LAT + 19);
        end
        wait_drain();
    endtask

    task automatic test_stall();
        int rr, gg, bb, n, seen;
        logic [3*CW-1:0] hold;
        for (int i = 0; i < 3; i++) begin
            rr = $urandom_range(0, MAXV);
            gg = $urandom_range(0, MAXV);
            bb = $urandom_range(0, MAXV);
            drive_pixel(rr, gg, bb, ref_hsv(rr, gg, bb));
        end
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checks++;
            if ({out_valid, h, s, v} !== {1'b0, last_exp}) begin
                errors++;
                $display("FAIL stall_mid: got ov=%0b h=%0d s=%0d v=%0d, expected frozen ov=0 hsv=%0h",
                         out_valid, h, s, v, last_exp);
            end
        end
        ce = 1'b1;
        n = 3; seen = 0;
        while (seen == 0 && n < 3 * LAT) begin
            @(posedge clock); #1;
            n++;
            if (out_valid) seen = n;
        end
        checks++;
        if (seen !== LAT) begin
            errors++;
            $display("FAIL stall_latency: got %0d ce-high cycles, expected %0d", seen, LAT);
        end
        ce = 1'b0;
        hold = (exp_q.size() != 0) ? exp_q[0] : '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checks++;
            if ({out_valid, h, s, v} !== {1'b1, hold}) begin
                errors++;
                $display("FAIL stall_hold: got ov=%0b h=%0d s=%0d v=%0d, expected ov=1 hsv=%0h",
                         out_valid, h, s, v, hold);
            end
        end
        ce = 1'b1;
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        int cnt;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            r = CW'($urandom_range(1, MAXV));
            g = CW'($urandom_range(0, MAXV));
            b = CW'($urandom_range(0, MAXV));
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        last_exp = '0;
        checks++;
        if ({out_valid, h, s, v} !== {1'b0, {3*CW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_async: got ov=%0b h=%0d s=%0d v=%0d, expected all 0", out_valid, h, s, v);
        end
        @(posedge clock); @(posedge clock);
        #3 reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clock); #1;
            if (out_valid) cnt++;
        end
        checks++;
        if (cnt !== 0) begin
            errors++;
            $display("FAIL reset_flush: got %0d stale beats, expected 0", cnt);
        end
        drive_pixel(30, 200, 90, ref_hsv(30, 200, 90));
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_recover: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        reset    = 1'b1;
        ce       = 1'b1;
        in_valid = 1'b0;
        r = '0;
        g = '0;
        b = '0;
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
